// File: rtl/adc_event_builder_if.sv
// Byte stream link from the event builder to the TCP transmit path.
// valid/ready handshake; EVB_LAST marks the final byte of an event.
interface adc_event_builder_if;
  logic [7:0] EVB_DATA;
  logic       EVB_VALID;
  logic       EVB_LAST;
  logic       EVB_READY;

  modport master (
    output EVB_DATA,
    output EVB_VALID,
    output EVB_LAST,
    input  EVB_READY
  );

  modport slave (
    input  EVB_DATA,
    input  EVB_VALID,
    input  EVB_LAST,
    output EVB_READY
  );
endinterface

// File: rtl/adc_event_builder.sv
// Captures a window of ADC samples per start-of-data and streams the
// event as header, LSB-first payload bytes and trailer; busy SODs are counted.
module adc_event_builder #(
  parameter int DATA_W  = 768,
  parameter int MAX_WIN = 16,
  parameter int WIN_AW  = 4
) (
  input  logic                   SYSCLK,
  input  logic                   sRST,
  input  logic                   ENABLE,
  input  logic [11:0]            REG_WINDOW,
  input  logic                   RAW_SOD,
  input  logic [31:0]            RAW_TRG_NUM,
  input  logic [DATA_W-1:0]      RAW_ADC,
  adc_event_builder_if.master    evb,
  output logic                   BUSY,
  output logic [15:0]            DROP_CNT
);

  localparam int NB = DATA_W / 8;
  localparam int BW = $clog2(NB);
  localparam logic [BW-1:0] BLAST = BW'(NB - 1);
  localparam logic [11:0] WMAX = 12'(MAX_WIN);

  typedef enum logic [2:0] {
    IDLE, CAPTURE, HEADER, PAYLOAD, TRAILER
  } state_t;

  state_t              state_q, state_d;
  logic [11:0]         w_q, w_d;
  logic [31:0]         trg_q, trg_d;
  logic [WIN_AW-1:0]   wcnt_q, wcnt_d;
  logic [WIN_AW-1:0]   sidx_q, sidx_d;
  logic [BW-1:0]       bidx_q, bidx_d;
  logic [2:0]          hcnt_q, hcnt_d;
  logic [7:0]          data_q, data_d;
  logic                valid_q, valid_d;
  logic                last_q, last_d;
  logic [15:0]         drop_q, drop_d;

  logic [DATA_W-1:0]   mem_q [MAX_WIN];
  logic [DATA_W-1:0]   samp_q;
  logic                we;
  logic [WIN_AW-1:0]   waddr;

  logic                sod;
  logic                load;
  logic [11:0]         w_clamp;
  logic [11:0]         w_last;
  logic [BW+2:0]       bsel;
  logic [7:0]          hdr_byte;

  assign sod  = RAW_SOD && ENABLE;
  assign load = !valid_q || evb.EVB_READY;
  assign w_last = w_q - 12'd1;
  assign bsel = {bidx_q, 3'b000};

  assign evb.EVB_DATA  = data_q;
  assign evb.EVB_VALID = valid_q;
  assign evb.EVB_LAST  = last_q;
  assign BUSY          = (state_q != IDLE);
  assign DROP_CNT      = drop_q;

  // Window clamp: zero means one sample, oversize means the buffer depth
  always_comb begin
    w_clamp = REG_WINDOW;
    if (REG_WINDOW == 12'd0)
      w_clamp = 12'd1;
    else if (REG_WINDOW > WMAX)
      w_clamp = WMAX;
  end

  // Header byte selected by the header counter
  always_comb begin
    hdr_byte = 8'h00;
    unique case (hcnt_q)
      3'd0: hdr_byte = 8'hAA;
      3'd1: hdr_byte = 8'h55;
      3'd2: hdr_byte = {4'h0, w_q[11:8]};
      3'd3: hdr_byte = w_q[7:0];
      3'd4: hdr_byte = trg_q[31:24];
      3'd5: hdr_byte = trg_q[23:16];
      3'd6: hdr_byte = trg_q[15:8];
      3'd7: hdr_byte = trg_q[7:0];
    endcase
  end

  // Next-state, buffer write and output-register generation
  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    trg_d   = trg_q;
    wcnt_d  = wcnt_q;
    sidx_d  = sidx_q;
    bidx_d  = bidx_q;
    hcnt_d  = hcnt_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    drop_d  = drop_q;
    we      = 1'b0;
    waddr   = wcnt_q;

    if (sod && state_q != IDLE && drop_q != 16'hFFFF)
      drop_d = drop_q + 16'd1;

    unique case (state_q)
      IDLE: begin
        if (sod) begin
          trg_d  = RAW_TRG_NUM;
          w_d    = w_clamp;
          we     = 1'b1;
          waddr  = '0;
          wcnt_d = WIN_AW'(1);
          hcnt_d = 3'd0;
          state_d = (w_clamp == 12'd1) ? HEADER : CAPTURE;
        end
      end
      CAPTURE: begin
        if (ENABLE) begin
          we     = 1'b1;
          wcnt_d = wcnt_q + WIN_AW'(1);
          if (12'(wcnt_q) == w_last)
            state_d = HEADER;
        end
      end
      HEADER: begin
        if (load) begin
          valid_d = 1'b1;
          data_d  = hdr_byte;
          hcnt_d  = hcnt_q + 3'd1;
          if (hcnt_q == 3'd7) begin
            state_d = PAYLOAD;
            sidx_d  = '0;
            bidx_d  = '0;
          end
        end
      end
      PAYLOAD: begin
        if (load) begin
          data_d = samp_q[bsel +: 8];
          if (bidx_q == BLAST) begin
            bidx_d = '0;
            if (12'(sidx_q) == w_last) begin
              state_d = TRAILER;
              hcnt_d  = 3'd0;
            end else begin
              sidx_d = sidx_q + WIN_AW'(1);
            end
          end else begin
            bidx_d = bidx_q + BW'(1);
          end
        end
      end
      TRAILER: begin
        if (load) begin
          unique case (hcnt_q)
            3'd0: begin
              data_d = 8'hEE;
              hcnt_d = 3'd1;
            end
            3'd1: begin
              data_d = 8'hEE;
              last_d = 1'b1;
              hcnt_d = 3'd2;
            end
            default: begin
              data_d  = 8'h00;
              valid_d = 1'b0;
              last_d  = 1'b0;
              state_d = IDLE;
            end
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and output registers with synchronous reset
  always_ff @(posedge SYSCLK) begin
    if (sRST) begin
      state_q <= IDLE;
      w_q     <= 12'd0;
      trg_q   <= 32'd0;
      wcnt_q  <= '0;
      sidx_q  <= '0;
      bidx_q  <= '0;
      hcnt_q  <= 3'd0;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      drop_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      trg_q   <= trg_d;
      wcnt_q  <= wcnt_d;
      sidx_q  <= sidx_d;
      bidx_q  <= bidx_d;
      hcnt_q  <= hcnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      drop_q  <= drop_d;
    end
  end

  // Sample buffer; reading at the next index keeps samp_q aligned with sidx_q
  always_ff @(posedge SYSCLK) begin
    if (we)
      mem_q[waddr] <= RAW_ADC;
    samp_q <= mem_q[sidx_d];
  end

endmodule

// File: tb/tb_adc_event_builder.sv
// Directed bench for adc_event_builder: table of events plus hand
// sequences for drops, last-cycle SOD and reset during readout.
module tb_adc_event_builder;
  localparam int DATA_W  = 768;
  localparam int MAX_WIN = 16;
  localparam int WIN_AW  = 4;
  localparam int NB      = 96;

  logic              SYSCLK = 1'b0;
  logic              sRST;
  logic              ENABLE;
  logic [11:0]       REG_WINDOW;
  logic              RAW_SOD;
  logic [31:0]       RAW_TRG_NUM;
  logic [DATA_W-1:0] RAW_ADC;
  logic              BUSY;
  logic [15:0]       DROP_CNT;

  adc_event_builder_if evb();

  adc_event_builder #(
    .DATA_W(DATA_W), .MAX_WIN(MAX_WIN), .WIN_AW(WIN_AW)
  ) dut (
    .SYSCLK(SYSCLK), .sRST(sRST), .ENABLE(ENABLE),
    .REG_WINDOW(REG_WINDOW), .RAW_SOD(RAW_SOD),
    .RAW_TRG_NUM(RAW_TRG_NUM), .RAW_ADC(RAW_ADC),
    .evb(evb), .BUSY(BUSY), .DROP_CNT(DROP_CNT)
  );

  always #5 SYSCLK = ~SYSCLK;

  int checks = 0;
  int errors = 0;
  int seq = 0;
  logic [7:0] expq[$];
  logic [7:0] gotq[$];
  logic [DATA_W-1:0] smp[$];

  typedef struct {
    logic [11:0] win;
    logic [31:0] trg;
    int rdy50;
    int pause_at;
    int pause_len;
    int exp_w;
    int exp_len;
  } vec_t;
  vec_t vt[7];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge SYSCLK);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] pat(input int n);
    logic [DATA_W-1:0] r;
    for (int k = 0; k < NB; k++)
      r[8*k +: 8] = 8'(n * 13 + k * 3 + 1);
    return r;
  endfunction

  // Drives one SOD and the enabled samples; builds the expected stream
  task automatic capture(input logic [11:0] win, input logic [31:0] trg,
                         input int exp_w, input int pause_at,
                         input int pause_len);
    int s;
    int p;
    logic [11:0] w12;
    smp.delete();
    REG_WINDOW  = win;
    RAW_TRG_NUM = trg;
    RAW_SOD     = 1'b1;
    ENABLE      = 1'b1;
    RAW_ADC     = pat(seq);
    seq++;
    smp.push_back(RAW_ADC);
    s = 1;
    p = 0;
    step();
    RAW_SOD     = 1'b0;
    REG_WINDOW  = 12'd7;
    RAW_TRG_NUM = 32'hDEADDEAD;
    while (s < exp_w) begin
      RAW_ADC = pat(seq);
      seq++;
      if (s == pause_at && p < pause_len) begin
        ENABLE = 1'b0;
        p++;
      end else begin
        ENABLE = 1'b1;
        smp.push_back(RAW_ADC);
        s++;
      end
      step();
    end
    ENABLE  = 1'b1;
    RAW_ADC = pat(seq);
    seq++;
    w12 = 12'(exp_w);
    expq.delete();
    expq.push_back(8'hAA);
    expq.push_back(8'h55);
    expq.push_back({4'h0, w12[11:8]});
    expq.push_back(w12[7:0]);
    expq.push_back(trg[31:24]);
    expq.push_back(trg[23:16]);
    expq.push_back(trg[15:8]);
    expq.push_back(trg[7:0]);
    foreach (smp[i])
      for (int k = 0; k < NB; k++)
        expq.push_back(smp[i][8*k +: 8]);
    expq.push_back(8'hEE);
    expq.push_back(8'hEE);
  endtask

  // Collects one event and checks latency, continuity, stalls and bytes
  task automatic drain(input int rdy50, input int drops, input int last_sod);
    int cyc;
    int gaps;
    int stall;
    int nm;
    logic pv, pr, pl, rdy, done;
    logic [7:0] pd;
    cyc = 0; gaps = 0; stall = 0; nm = 0;
    pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = 8'h00; done = 1'b0;
    gotq.delete();
    chk("lat_lo", evb.EVB_VALID, 0);
    chk("busy_cap", BUSY, 1);
    while (!done && cyc < 10000) begin
      if (cyc == 1)
        chk("lat_hi", evb.EVB_VALID, 1);
      if (cyc >= 1 && !evb.EVB_VALID)
        gaps++;
      if (pv && !pr && (evb.EVB_DATA != pd || evb.EVB_LAST != pl))
        stall++;
      rdy = (rdy50 != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      evb.EVB_READY = rdy;
      RAW_SOD = 1'b0;
      ENABLE  = 1'($urandom_range(0, 1));
      if (drops != 0 && (cyc == 20 || cyc == 60 || cyc == 120)) begin
        RAW_SOD = 1'b1;
        ENABLE  = 1'b1;
      end
      if (drops != 0 && cyc == 90) begin
        RAW_SOD = 1'b1;
        ENABLE  = 1'b0;
      end
      if (evb.EVB_VALID && rdy) begin
        gotq.push_back(evb.EVB_DATA);
        if (evb.EVB_LAST) begin
          done = 1'b1;
          if (last_sod != 0) begin
            RAW_SOD = 1'b1;
            ENABLE  = 1'b1;
          end
        end
      end
      pv = evb.EVB_VALID;
      pr = rdy;
      pd = evb.EVB_DATA;
      pl = evb.EVB_LAST;
      step();
      cyc++;
    end
    RAW_SOD = 1'b0;
    ENABLE  = 1'b1;
    chk("timeout", done, 1);
    chk("len", gotq.size(), expq.size());
    foreach (gotq[i])
      if (i < expq.size() && gotq[i] != expq[i])
        nm++;
    chk("bytes_mism", nm, 0);
    chk("valid_gap", gaps, 0);
    chk("stall_hold", stall, 0);
    chk("end_valid", evb.EVB_VALID, 0);
    chk("end_busy", BUSY, 0);
  endtask

  initial begin
    vt[0] = '{12'd2,   32'h12345678, 0, -1, 0, 2,  202};
    vt[1] = '{12'd2,   32'h12345678, 1, -1, 0, 2,  202};
    vt[2] = '{12'd0,   32'hCAFEBABE, 0, -1, 0, 1,  106};
    vt[3] = '{12'd100, 32'h0BADF00D, 0, -1, 0, 16, 1546};
    vt[4] = '{12'd4,   32'hA5A50001, 0, 2,  3, 4,  394};
    vt[5] = '{12'd16,  32'h0000FFFF, 1, -1, 0, 16, 1546};
    vt[6] = '{12'hFFF, 32'h80000001, 0, -1, 0, 16, 1546};

    sRST = 1'b1;
    ENABLE = 1'b0;
    RAW_SOD = 1'b0;
    REG_WINDOW = 12'd0;
    RAW_TRG_NUM = 32'd0;
    RAW_ADC = '0;
    evb.EVB_READY = 1'b0;
    repeat (3) step();
    sRST = 1'b0;
    step();
    chk("rst_valid", evb.EVB_VALID, 0);
    chk("rst_last", evb.EVB_LAST, 0);
    chk("rst_data", evb.EVB_DATA, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_drop", DROP_CNT, 0);

    RAW_SOD = 1'b1;
    ENABLE  = 1'b0;
    step();
    RAW_SOD = 1'b0;
    step();
    chk("sod_disabled_busy", BUSY, 0);
    chk("sod_disabled_drop", DROP_CNT, 0);

    for (int i = 0; i < 7; i++) begin
      capture(vt[i].win, vt[i].trg, vt[i].exp_w,
              vt[i].pause_at, vt[i].pause_len);
      drain(vt[i].rdy50, 0, 0);
      chk("tbl_len", gotq.size(), vt[i].exp_len);
    end

    capture(12'd2, 32'h11112222, 2, -1, 0);
    drain(0, 1, 0);
    chk("drop3", DROP_CNT, 3);

    capture(12'd1, 32'h33334444, 1, -1, 0);
    drain(0, 0, 1);
    chk("drop_last", DROP_CNT, 4);

    capture(12'd2, 32'h55556666, 2, -1, 0);
    evb.EVB_READY = 1'b1;
    repeat (60) step();
    chk("mid_valid", evb.EVB_VALID, 1);
    chk("mid_busy", BUSY, 1);
    sRST = 1'b1;
    step();
    sRST = 1'b0;
    chk("mrst_valid", evb.EVB_VALID, 0);
    chk("mrst_last", evb.EVB_LAST, 0);
    chk("mrst_data", evb.EVB_DATA, 0);
    chk("mrst_busy", BUSY, 0);
    chk("mrst_drop", DROP_CNT, 0);

    capture(12'd3, 32'h9ABCDEF0, 3, -1, 0);
    drain(1, 0, 0);
    chk("post_rst_len", gotq.size(), 298);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
